// File: rtl/jk_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jk_mon_pkg
// Description : Shared types and helpers for the JK Q run logger.
// Revision    : 1.0 - initial release
// ============================================================================
package jk_mon_pkg;

    localparam int c_cw_default    = 8;
    localparam int c_tw_default    = 16;
    localparam int c_depth_default = 4;

    typedef struct packed {
        logic                    level;
        logic [c_cw_default-1:0] len;
    } rec_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_TRACK = 1'b1
    } trk_state_t;

    function automatic int unsigned sat_inc(input int unsigned value,
                                            input int unsigned max_value);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jk_rec_fifo.sv
`default_nettype none
// ============================================================================
// Module      : jk_rec_fifo
// Description : First-word-fall-through record FIFO; a push while full is
//               only taken when a pop frees the head slot on the same edge.
// Revision    : 1.0 - initial release
// ============================================================================
module jk_rec_fifo
    import jk_mon_pkg::*;
#(
    parameter type T     = rec_t,
    parameter int  DEPTH = c_depth_default
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  T                         push_data,
    input  logic                     pop,
    output T                         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int c_aw = $clog2(DEPTH);

    logic [c_aw:0] r_wr_ptr;
    logic [c_aw:0] r_rd_ptr;
    T              r_mem [DEPTH];

    logic [c_aw:0] w_level;
    logic          w_wr;
    logic          w_rd;

    // Pointers carry one extra bit so full and empty stay distinguishable.
    assign w_level = r_wr_ptr - r_rd_ptr;
    assign empty   = (r_wr_ptr == r_rd_ptr);
    assign full    = (w_level == (c_aw+1)'(DEPTH));
    assign level   = w_level;

    assign w_rd = pop && !empty;
    assign w_wr = push && (!full || w_rd);

    assign head = empty ? T'('0) : r_mem[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + (c_aw+1)'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + (c_aw+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/jk_q_run_logger.sv
`default_nettype none
// ============================================================================
// Module      : jk_q_run_logger
// Description : Measures run lengths of the JK flip-flop Q output, counts
//               transitions and queues {level, length} records for draining.
// Revision    : 1.0 - initial release
// ============================================================================
module jk_q_run_logger
    import jk_mon_pkg::*;
#(
    parameter int CW    = c_cw_default,
    parameter int TW    = c_tw_default,
    parameter int DEPTH = c_depth_default
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   q,
    input  logic                   en,
    input  logic                   clr_ovf,
    input  logic                   rec_ready,
    output logic                   rec_valid,
    output logic                   rec_level,
    output logic [CW-1:0]          rec_len,
    output logic [TW-1:0]          toggle_cnt,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] fifo_level
);

    localparam int unsigned c_len_max = (32'd1 << CW) - 32'd1;

    typedef struct packed {
        logic          level;
        logic [CW-1:0] len;
    } run_rec_t;

    trk_state_t    r_state;
    trk_state_t    w_state_nxt;
    logic          r_q_prev;
    logic [CW-1:0] r_run_len;
    logic [TW-1:0] r_toggle_cnt;
    logic          r_overflow;

    logic          w_load;
    logic          w_extend;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          w_drop;
    run_rec_t      w_push_rec;
    run_rec_t      w_head;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Tracker decisions; with en low nothing advances, so a Q change made
    // during the freeze shows up as a transition on re-enable.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_extend    = 1'b0;
        w_push      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (en) begin
                    if (q != r_q_prev) begin
                        w_push = 1'b1;
                        w_load = 1'b1;
                    end else begin
                        w_extend = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q_prev     <= 1'b0;
            r_run_len    <= '0;
            r_toggle_cnt <= '0;
        end else begin
            if (w_load) begin
                r_q_prev  <= q;
                r_run_len <= CW'(1);
            end else if (w_extend) begin
                r_run_len <= CW'(sat_inc(32'(r_run_len), c_len_max));
            end
            if (w_push) begin
                r_toggle_cnt <= r_toggle_cnt + TW'(1);
            end
        end
    end

    assign w_pop  = rec_valid && rec_ready;
    assign w_drop = w_push && w_full && !w_pop;

    // A drop on the same edge as a clear must leave the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    assign w_push_rec.level = r_q_prev;
    assign w_push_rec.len   = r_run_len;

    jk_rec_fifo #(
        .T     (run_rec_t),
        .DEPTH (DEPTH)
    ) u_rec_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_rec),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .level     (fifo_level)
    );

    assign rec_valid  = !w_empty;
    assign rec_level  = w_head.level;
    assign rec_len    = w_head.len;
    assign toggle_cnt = r_toggle_cnt;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_jk_q_run_logger.sv
`default_nettype none
// ============================================================================
// Module      : tb_jk_q_run_logger
// Description : Directed, table-driven bench for jk_q_run_logger.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_q_run_logger;

    logic        clk = 1'b0;
    logic        rst;
    logic        q;
    logic        en;
    logic        clr_ovf;
    logic        rec_ready;
    logic        rec_valid;
    logic        rec_level;
    logic [7:0]  rec_len;
    logic [15:0] toggle_cnt;
    logic        overflow;
    logic [2:0]  fifo_level;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        q;
        logic        en;
        logic        rdy;
        logic        clr;
        logic        v;
        logic        l;
        logic [7:0]  len;
        logic [15:0] tog;
        logic [2:0]  fl;
        logic        ovf;
    } vec_t;

    vec_t vecs [12];

    jk_q_run_logger #(
        .CW    (8),
        .TW    (16),
        .DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .q          (q),
        .en         (en),
        .clr_ovf    (clr_ovf),
        .rec_ready  (rec_ready),
        .rec_valid  (rec_valid),
        .rec_level  (rec_level),
        .rec_len    (rec_len),
        .toggle_cnt (toggle_cnt),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input int vq, input int ven, input int vrdy,
                                input int vclr, input int vv, input int vl,
                                input int vlen, input int vtog, input int vfl,
                                input int vovf);
        vec_t r;
        r.q   = vq[0];
        r.en  = ven[0];
        r.rdy = vrdy[0];
        r.clr = vclr[0];
        r.v   = vv[0];
        r.l   = vl[0];
        r.len = vlen[7:0];
        r.tog = vtog[15:0];
        r.fl  = vfl[2:0];
        r.ovf = vovf[0];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int v, input int l,
                         input int len, input int tog, input int fl,
                         input int ovf);
        logic [29:0] act;
        logic [29:0] exp;
        act = {rec_valid, rec_level, rec_len, toggle_cnt, fifo_level, overflow};
        exp = {v[0], l[0], len[7:0], tog[15:0], fl[2:0], ovf[0]};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got valid=%0b level=%0b len=%0d toggles=%0d fifo_level=%0d ovf=%0b, want valid=%0d level=%0d len=%0d toggles=%0d fifo_level=%0d ovf=%0d",
                     name, rec_valid, rec_level, rec_len, toggle_cnt, fifo_level,
                     overflow, v, l, len, tog, fl, ovf);
        end
    endtask

    task automatic run(input int level, input int n);
        q = level[0];
        repeat (n) step();
    endtask

    // Called just after an edge, so the pulse sits between edges.
    task automatic do_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lv [4];
        int ln [4];

        // q  en rdy clr | valid level len tog fl ovf
        vecs[0]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[3]  = mk(1, 1, 0, 0, 1, 0, 3, 1, 1, 0);
        vecs[4]  = mk(1, 1, 0, 0, 1, 0, 3, 1, 1, 0);
        vecs[5]  = mk(1, 1, 0, 0, 1, 0, 3, 1, 1, 0);
        vecs[6]  = mk(1, 1, 0, 0, 1, 0, 3, 1, 1, 0);
        vecs[7]  = mk(1, 1, 0, 0, 1, 0, 3, 1, 1, 0);
        vecs[8]  = mk(0, 1, 0, 0, 1, 0, 3, 2, 2, 0);
        vecs[9]  = mk(0, 1, 1, 0, 1, 1, 5, 2, 1, 0);
        vecs[10] = mk(0, 1, 1, 1, 0, 0, 0, 2, 0, 0);
        vecs[11] = mk(0, 1, 1, 0, 0, 0, 0, 2, 0, 0);

        rst = 1'b1; q = 1'b0; en = 1'b0; clr_ovf = 1'b0; rec_ready = 1'b0;
        #1 rst = 1'b0;
        #2 check("reset_state", 0, 0, 0, 0, 0, 0);
        #1 rst = 1'b1;

        // Basic runs: {0,3} then {1,5}, then drain.
        for (int i = 0; i < 12; i++) begin
            q = vecs[i].q; en = vecs[i].en; rec_ready = vecs[i].rdy; clr_ovf = vecs[i].clr;
            step();
            check($sformatf("basic_vec%0d", i), vecs[i].v, vecs[i].l, vecs[i].len,
                  vecs[i].tog, vecs[i].fl, vecs[i].ovf);
        end
        rec_ready = 1'b0; clr_ovf = 1'b0;

        // Saturation at 255, and a 254 run just under the ceiling.
        do_reset();
        en = 1'b1;
        run(1, 300);
        check("sat_no_record_yet", 0, 0, 0, 0, 0, 0);
        run(0, 254);
        check("sat_record_255", 1, 1, 255, 1, 1, 0);
        run(1, 1);
        check("sat_second_push", 1, 1, 255, 2, 2, 0);
        rec_ready = 1'b1;
        step();
        rec_ready = 1'b0;
        check("sat_record_254", 1, 0, 254, 2, 1, 0);

        // Overflow and drain.
        do_reset();
        en = 1'b1;
        run(0, 1); run(1, 2); run(0, 3); run(1, 4); run(0, 5);
        check("ovf_full", 1, 0, 1, 4, 4, 0);
        run(1, 6);
        check("ovf_first_drop", 1, 0, 1, 5, 4, 1);
        run(0, 1);
        check("ovf_second_drop", 1, 0, 1, 6, 4, 1);
        lv = '{0, 1, 0, 1};
        ln = '{1, 2, 3, 4};
        en = 1'b0; rec_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("ovf_drain%0d", k), 1, lv[k], ln[k], 6, 4 - k, 1);
            step();
        end
        check("ovf_drained", 0, 0, 0, 6, 0, 1);
        rec_ready = 1'b0; clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("ovf_cleared", 0, 0, 0, 6, 0, 0);

        // Enable freeze.
        do_reset();
        en = 1'b1;
        run(1, 2);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            q = ~q;
            step();
        end
        check("freeze_hold", 0, 0, 0, 0, 0, 0);
        en = 1'b1;
        run(1, 3);
        check("freeze_resumed", 0, 0, 0, 0, 0, 0);
        run(0, 1);
        check("freeze_record", 1, 1, 5, 1, 1, 0);

        // Full FIFO with push and pop on one edge, then drop versus clear.
        do_reset();
        en = 1'b1;
        run(0, 1); run(1, 2); run(0, 3); run(1, 4); run(0, 5);
        check("pp_full", 1, 0, 1, 4, 4, 0);
        q = 1'b1; rec_ready = 1'b1;
        step();
        rec_ready = 1'b0;
        check("pp_push_pop_full", 1, 1, 2, 5, 4, 0);
        q = 1'b0; clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("pp_drop_beats_clear", 1, 1, 2, 6, 4, 1);
        lv = '{1, 0, 1, 0};
        ln = '{2, 3, 4, 5};
        en = 1'b0; rec_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("pp_drain%0d", k), 1, lv[k], ln[k], 6, 4 - k, 1);
            step();
        end
        check("pp_drained", 0, 0, 0, 6, 0, 1);
        rec_ready = 1'b0;

        // Asynchronous reset mid-operation.
        do_reset();
        en = 1'b1;
        run(0, 2); run(1, 2); run(0, 1);
        check("ar_two_records", 1, 0, 2, 2, 2, 0);
        #2 rst = 1'b0;
        #1 check("ar_immediate", 0, 0, 0, 0, 0, 0);
        #1 rst = 1'b1;
        q = 1'b1;
        step();
        check("ar_rearm_no_record", 0, 0, 0, 0, 0, 0);
        q = 1'b0;
        step();
        check("ar_first_record", 1, 1, 1, 1, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
